// File: rtl/spi_master_shifter_if.sv
// Control/data bundle between apb_slave_interface and spi_master_shifter.
// loopback_i exists only when SPI_LOOPBACK_EN is defined.
interface spi_master_shifter_if #(
    parameter int DATA_W = 8
);
    logic              spe_i;
    logic              mstr_i;
    logic              cpol_i;
    logic              cpha_i;
    logic              lsbfe_i;
    logic [2:0]        sppr_i;
    logic [2:0]        spr_i;
    logic              send_data_i;
    logic [DATA_W-1:0] mosi_data_i;
    logic              miso_i;
`ifdef SPI_LOOPBACK_EN
    logic              loopback_i;
`endif
    logic              sclk_o;
    logic              mosi_o;
    logic              ss_o;
    logic              tip_o;
    logic              receive_data_o;
    logic [DATA_W-1:0] miso_data_o;

    modport master (
`ifdef SPI_LOOPBACK_EN
        output loopback_i,
`endif
        output spe_i, mstr_i, cpol_i, cpha_i, lsbfe_i,
        output sppr_i, spr_i, send_data_i, mosi_data_i, miso_i,
        input  sclk_o, mosi_o, ss_o, tip_o,
        input  receive_data_o, miso_data_o
    );

    modport slave (
`ifdef SPI_LOOPBACK_EN
        input  loopback_i,
`endif
        input  spe_i, mstr_i, cpol_i, cpha_i, lsbfe_i,
        input  sppr_i, spr_i, send_data_i, mosi_data_i, miso_i,
        output sclk_o, mosi_o, ss_o, tip_o,
        output receive_data_o, miso_data_o
    );
endinterface

// File: rtl/spi_master_shifter.sv
// SPI master shifter: SCLK generation, MOSI serialiser, MISO capture.
// Optional macro SPI_LOOPBACK_EN adds loopback_i (sample mosi_o instead of miso_i).
module spi_master_shifter #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 11
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    spi_master_shifter_if.slave  bus
);
    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t            state_q;
    state_t            state_d;
    logic              cpol_q;
    logic              cpha_q;
    logic              lsbfe_q;
    logic [DIV_W-1:0]  half_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [EW-1:0]     edge_q;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] rx_data_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              rcv_q;

    logic              start;
    logic              abort;
    logic              sclk_edge;
    logic              finish;
    logic              tick;
    logic              drive;
    logic              sample;
    logic              miso_bit;
    logic [DIV_W-1:0]  half_d;

    assign half_d = DIV_W'({1'b0, bus.sppr_i} + 4'd1) << bus.spr_i;
    assign tick   = (cnt_q == half_q - DIV_W'(1));

    // Even edge counts are leading edges, odd counts trailing.
    assign drive  = sclk_edge & (cpha_q ? ~edge_q[0]
                                        : (edge_q[0] & (edge_q != LAST_EDGE)));
    assign sample = sclk_edge & (cpha_q ? edge_q[0] : ~edge_q[0]);

`ifdef SPI_LOOPBACK_EN
    assign miso_bit = bus.loopback_i ? mosi_q : bus.miso_i;
`else
    assign miso_bit = bus.miso_i;
`endif

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        abort     = 1'b0;
        sclk_edge = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.send_data_i && bus.spe_i && bus.mstr_i) begin
                    start   = 1'b1;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (tick) state_d = XFER;
            end
            XFER: begin
                if (tick) begin
                    sclk_edge = 1'b1;
                    if (edge_q == LAST_EDGE) state_d = TRAIL;
                end
            end
            TRAIL: begin
                if (tick) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !bus.spe_i) begin
            abort     = 1'b1;
            sclk_edge = 1'b0;
            finish    = 1'b0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsbfe_q   <= 1'b0;
            half_q    <= DIV_W'(1);
            cnt_q     <= '0;
            edge_q    <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data_q <= '0;
            sclk_q    <= bus.cpol_i;
            mosi_q    <= 1'b0;
            rcv_q     <= 1'b0;
        end else begin
            rcv_q <= finish;
            if (start) begin
                cpol_q  <= bus.cpol_i;
                cpha_q  <= bus.cpha_i;
                lsbfe_q <= bus.lsbfe_i;
                half_q  <= half_d;
                cnt_q   <= '0;
                edge_q  <= '0;
                rx_sr   <= '0;
                sclk_q  <= bus.cpol_i;
                if (bus.cpha_i) begin
                    tx_sr <= bus.mosi_data_i;
                end else begin
                    // First bit must be on the line before the first leading edge.
                    mosi_q <= bus.lsbfe_i ? bus.mosi_data_i[0]
                                          : bus.mosi_data_i[DATA_W-1];
                    tx_sr  <= bus.lsbfe_i ? bus.mosi_data_i >> 1
                                          : bus.mosi_data_i << 1;
                end
            end else if (abort) begin
                sclk_q <= cpol_q;
                cnt_q  <= '0;
                edge_q <= '0;
            end else if (state_q == IDLE) begin
                sclk_q <= bus.cpol_i;
                cnt_q  <= '0;
                edge_q <= '0;
            end else begin
                cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
                if (sclk_edge) begin
                    sclk_q <= ~sclk_q;
                    edge_q <= edge_q + EW'(1);
                end
                if (drive) begin
                    mosi_q <= lsbfe_q ? tx_sr[0] : tx_sr[DATA_W-1];
                    tx_sr  <= lsbfe_q ? tx_sr >> 1 : tx_sr << 1;
                end
                if (sample) begin
                    rx_sr <= lsbfe_q ? {miso_bit, rx_sr[DATA_W-1:1]}
                                     : {rx_sr[DATA_W-2:0], miso_bit};
                end
                if (finish) rx_data_q <= rx_sr;
            end
        end
    end

    assign bus.sclk_o         = sclk_q;
    assign bus.mosi_o         = mosi_q;
    assign bus.ss_o           = (state_q == IDLE);
    assign bus.tip_o          = (state_q != IDLE);
    assign bus.receive_data_o = rcv_q;
    assign bus.miso_data_o    = rx_data_q;
endmodule
